// File: rtl/bus_ram_pkg.sv
// Shared nqcpu memory-bus types: handshake states, bus widths and the request bundle
// that bus slaves such as testROM and bus_ram decode.
package bus_ram_pkg;

    localparam int unsigned BUS_ADDR_W = 24;
    localparam int unsigned BUS_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic                  re;
        logic                  we;
    } bus_req_t;

endpackage

// File: rtl/ram_array.sv
// Single-port word RAM: synchronous write, registered read with a resettable output register.
module ram_array
    import bus_ram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [BUS_DATA_W-1:0] wdata_i,
    output logic [BUS_DATA_W-1:0] rdata_o
);

    logic [BUS_DATA_W-1:0] mem_q [2**ADDR_BITS];
    logic [BUS_DATA_W-1:0] rdata_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ram.sv
// Writable RAM slave on the nqcpu memory bus with a needWait stall handshake,
// window decode, abort and illegal-request detection.
module bus_ram
    import bus_ram_pkg::*;
#(
    parameter int unsigned           ADDR_BITS   = 10,
    parameter logic [BUS_ADDR_W-1:0] BASE        = 24'h010000,
    parameter int unsigned           WAIT_CYCLES = 1,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] addr_i,
    input  logic                  re_i,
    input  logic                  we_i,
    inout  wire  [BUS_DATA_W-1:0] data_io,
    output logic                  needWait_o,
    output logic                  busErr_o
);

    localparam int unsigned TagLo = ADDR_BITS + 1;

    bus_req_t bus;
    logic     sel, req, illegal, unused_addr0;

    assign bus          = '{addr: addr_i, re: re_i, we: we_i};
    assign unused_addr0 = bus.addr[0];
    assign sel          = bus.addr[BUS_ADDR_W-1:TagLo] == BASE[BUS_ADDR_W-1:TagLo];
    assign req          = sel & (bus.re ^ bus.we);
    assign illegal      = sel & bus.re & bus.we;

    bus_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
    logic                  oe_q, oe_d;
    logic                  berr_q, berr_d;

    logic                  ram_we, ram_re;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [BUS_DATA_W-1:0] ram_wdata, ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        oe_d       = 1'b0;
        berr_d     = 1'b0;
        needWait_o = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = idx_q;
        ram_wdata  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    needWait_o = 1'b1;
                    idx_d      = bus.addr[ADDR_BITS:1];
                    wr_d       = bus.we;
                    wdata_d    = data_io;
                    cnt_d      = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the RAM access happens on the edge leaving IDLE.
                        state_d   = DONE;
                        ram_addr  = bus.addr[ADDR_BITS:1];
                        ram_wdata = data_io;
                        ram_we    = bus.we;
                        ram_re    = bus.re;
                        oe_d      = bus.re;
                    end else begin
                        state_d = BUSY;
                    end
                end else if (illegal) begin
                    berr_d = 1'b1;
                end
            end
            BUSY: begin
                needWait_o = 1'b1;
                if (!bus.re && !bus.we) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                        ram_we  = wr_q;
                        ram_re  = !wr_q;
                        oe_d    = !wr_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            berr_q  <= berr_d;
        end
    end

    ram_array #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Registered enable keeps the bus released except during a read's DONE cycle.
    assign data_io  = oe_q ? ram_rdata : {BUS_DATA_W{1'bz}};
    assign busErr_o = berr_q;

endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: four instances with WAIT_CYCLES 1, 0, 3, 2 on separate pulled-up buses.
module tb_bus_ram;

    localparam logic [15:0] WCS  = {4'd2, 4'd3, 4'd0, 4'd1};
    // Released bus reads as the pull-up value.
    localparam logic [15:0] BUSZ = 16'hFFFF;

    logic        clk = 1'b0;
    logic [3:0]  rst = 4'hF;
    logic [3:0]  re  = 4'h0;
    logic [3:0]  we  = 4'h0;
    logic [3:0]  drv = 4'h0;
    logic [23:0] addr  = 24'h0;
    logic [15:0] wdata = 16'h0;
    wire  [15:0] rd [4];
    wire  [3:0]  nw, be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        tri1 [15:0] dbus;
        assign dbus  = drv[g] ? wdata : 16'hzzzz;
        assign rd[g] = dbus;
        bus_ram #(
            .WAIT_CYCLES (int'(WCS[g*4 +: 4]))
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .addr_i     (addr),
            .re_i       (re[g]),
            .we_i       (we[g]),
            .data_io    (dbus),
            .needWait_o (nw[g]),
            .busErr_o   (be[g])
        );
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        chk(tag, {15'd0, got}, {15'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move from just after the edge to the falling edge for sampling.
    task automatic probe();
        #4;
    endtask

    initial begin
        tick();
        tick();
        rst = 4'h0;
        probe();
        chk1("rst_nw0", nw[0], 1'b0);
        chk1("rst_nw1", nw[1], 1'b0);
        chk1("rst_be0", be[0], 1'b0);
        chk("rst_bus0", rd[0], BUSZ);
        tick();

        // WAIT_CYCLES=1: write BEEF to 010004.
        addr = 24'h010004; wdata = 16'hBEEF; we[0] = 1'b1; drv[0] = 1'b1;
        probe(); chk1("wr_req_nw", nw[0], 1'b1); tick();
        probe(); chk1("wr_busy_nw", nw[0], 1'b1); tick();
        probe(); chk1("wr_done_nw", nw[0], 1'b0); tick();
        we[0] = 1'b0; drv[0] = 1'b0;
        probe(); chk("wr_after_bus", rd[0], BUSZ); tick();

        // Read it back.
        re[0] = 1'b1;
        probe(); chk1("rd_req_nw", nw[0], 1'b1); chk("rd_req_bus", rd[0], BUSZ); tick();
        probe(); chk1("rd_busy_nw", nw[0], 1'b1); chk("rd_busy_bus", rd[0], BUSZ); tick();
        probe(); chk1("rd_done_nw", nw[0], 1'b0); chk("rd_done_bus", rd[0], 16'hBEEF); tick();
        re[0] = 1'b0;
        probe(); chk("rd_after_bus", rd[0], BUSZ); chk1("rd_after_nw", nw[0], 1'b0); tick();

        // WAIT_CYCLES=0: back-to-back writes preload 1111/2222, then back-to-back reads.
        addr = 24'h010000; wdata = 16'h1111; we[1] = 1'b1; drv[1] = 1'b1;
        probe(); chk1("w0_req_nw", nw[1], 1'b1); tick();
        addr = 24'h010002; wdata = 16'h2222;
        probe(); chk1("w0_done_nw", nw[1], 1'b0); tick();
        tick();
        we[1] = 1'b0; drv[1] = 1'b0;
        tick();
        addr = 24'h010000; re[1] = 1'b1;
        probe(); chk1("b2b_nw_a", nw[1], 1'b1); chk("b2b_bus_a", rd[1], BUSZ); tick();
        addr = 24'h010002;
        probe(); chk1("b2b_nw_b", nw[1], 1'b0); chk("b2b_data1", rd[1], 16'h1111); tick();
        probe(); chk1("b2b_nw_c", nw[1], 1'b1); chk("b2b_bus_c", rd[1], BUSZ); tick();
        probe(); chk1("b2b_nw_d", nw[1], 1'b0); chk("b2b_data2", rd[1], 16'h2222); tick();
        re[1] = 1'b0;
        probe(); chk("b2b_after_bus", rd[1], BUSZ); tick();

        // Out-of-window read held for five cycles.
        addr = 24'h020000; re[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            probe();
            chk1("oow_nw", nw[0], 1'b0);
            chk1("oow_be", be[0], 1'b0);
            chk("oow_bus", rd[0], BUSZ);
            tick();
        end
        re[0] = 1'b0;

        // WAIT_CYCLES=3: store 0000 at 010008, then abort a 5A5A write.
        addr = 24'h010008; wdata = 16'h0000; we[2] = 1'b1; drv[2] = 1'b1;
        repeat (5) tick();
        we[2] = 1'b0; drv[2] = 1'b0;
        tick();
        wdata = 16'h5A5A; we[2] = 1'b1; drv[2] = 1'b1;
        probe(); chk1("ab_req_nw", nw[2], 1'b1); tick();
        probe(); chk1("ab_b1_nw", nw[2], 1'b1); tick();
        we[2] = 1'b0; drv[2] = 1'b0;
        probe(); chk1("ab_b2_nw", nw[2], 1'b1); tick();
        probe(); chk1("ab_idle_nw", nw[2], 1'b0); tick();
        re[2] = 1'b1;
        repeat (3) tick();
        probe(); chk1("ab_rd_b3_nw", nw[2], 1'b1); tick();
        probe(); chk1("ab_rd_done_nw", nw[2], 1'b0); chk("ab_old_data", rd[2], 16'h0000); tick();
        re[2] = 1'b0;
        tick();

        // Illegal request at 010000 on the WAIT_CYCLES=1 instance.
        addr = 24'h010000; wdata = 16'h1234; we[0] = 1'b1; drv[0] = 1'b1;
        repeat (3) tick();
        we[0] = 1'b0; drv[0] = 1'b0;
        tick();
        wdata = 16'hDEAD; re[0] = 1'b1; we[0] = 1'b1;
        probe(); chk1("ill_req_nw", nw[0], 1'b0); chk1("ill_req_be", be[0], 1'b0); tick();
        re[0] = 1'b0; we[0] = 1'b0;
        probe(); chk1("ill_be_pulse", be[0], 1'b1); chk1("ill_nw", nw[0], 1'b0); tick();
        probe(); chk1("ill_be_clear", be[0], 1'b0); tick();
        re[0] = 1'b1;
        tick(); tick();
        probe(); chk("ill_ram_intact", rd[0], 16'h1234); tick();
        re[0] = 1'b0;
        tick();

        // WAIT_CYCLES=2: store 7E57 at 010006, then reset during a read's first BUSY cycle.
        addr = 24'h010006; wdata = 16'h7E57; we[3] = 1'b1; drv[3] = 1'b1;
        repeat (4) tick();
        we[3] = 1'b0; drv[3] = 1'b0;
        tick();
        re[3] = 1'b1;
        probe(); chk1("rr_req_nw", nw[3], 1'b1); tick();
        rst[3] = 1'b1;
        probe(); chk1("rr_busy_nw", nw[3], 1'b1); tick();
        rst[3] = 1'b0; re[3] = 1'b0;
        probe(); chk1("rr_post_nw", nw[3], 1'b0); chk("rr_post_bus", rd[3], BUSZ); tick();
        probe(); chk("rr_post2_bus", rd[3], BUSZ); tick();
        re[3] = 1'b1;
        repeat (3) tick();
        probe(); chk("rr_intact", rd[3], 16'h7E57); tick();
        re[3] = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
